// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then shifts
// one command byte plus odd parity out on device-generated clocks and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int STA_W = $clog2(START_TIMEOUT + 1);
    localparam int XFR_W = $clog2(XFER_TIMEOUT + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [STA_W-1:0] STA_LAST = STA_W'(START_TIMEOUT - 1);
    localparam logic [STA_W-1:0] STA_MAX  = STA_W'(START_TIMEOUT);
    localparam logic [XFR_W-1:0] XFR_LAST = XFR_W'(XFER_TIMEOUT - 1);
    localparam logic [XFR_W-1:0] XFR_MAX  = XFR_W'(XFER_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_clk_meta, r_clk_sync, r_clk_prev;
    logic             r_data_meta, r_data_sync;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
    logic [STA_W-1:0] r_start_cnt, w_start_cnt_nxt, w_start_inc;
    logic [XFR_W-1:0] r_xfer_cnt, w_xfer_cnt_nxt, w_xfer_inc;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [8:0]       r_shift, w_shift_nxt;
    logic             w_clk_low_nxt, w_data_low_nxt, w_done_nxt, w_err_nxt;
    logic             w_fe, w_start_to, w_xfer_to;

    assign w_fe        = r_clk_prev & ~r_clk_sync;
    assign w_start_to  = (r_start_cnt == STA_LAST);
    assign w_xfer_to   = (r_xfer_cnt == XFR_LAST);
    assign w_start_inc = (r_start_cnt == STA_MAX) ? r_start_cnt : r_start_cnt + STA_W'(1);
    assign w_xfer_inc  = (r_xfer_cnt == XFR_MAX) ? r_xfer_cnt : r_xfer_cnt + XFR_W'(1);

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        w_state_nxt     = r_state;
        w_inh_cnt_nxt   = r_inh_cnt;
        w_start_cnt_nxt = r_start_cnt;
        w_xfer_cnt_nxt  = r_xfer_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_clk_low_nxt   = 1'b0;
        w_data_low_nxt  = ps2_data_drive_low;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_low_nxt = 1'b0;
                if (tx_valid) begin
                    w_state_nxt    = S_INHIBIT;
                    w_shift_nxt    = {~^tx_data, tx_data};
                    w_inh_cnt_nxt  = '0;
                    w_clk_low_nxt  = 1'b1;
                    w_data_low_nxt = (INH_LAST == '0);
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_nxt     = S_REQ;
                    w_data_low_nxt  = 1'b1;
                    w_start_cnt_nxt = '0;
                end else begin
                    w_inh_cnt_nxt  = r_inh_cnt + INH_W'(1);
                    w_clk_low_nxt  = 1'b1;
                    // Start bit overlaps the last inhibit cycle.
                    w_data_low_nxt = (w_inh_cnt_nxt == INH_LAST);
                end
            end
            S_REQ: begin
                if (w_start_to) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_data_low_nxt = 1'b0;
                end else if (w_fe) begin
                    w_state_nxt    = S_SEND;
                    w_bit_cnt_nxt  = '0;
                    w_xfer_cnt_nxt = '0;
                    w_data_low_nxt = ~r_shift[0];
                    w_shift_nxt    = {1'b1, r_shift[8:1]};
                end else begin
                    w_start_cnt_nxt = w_start_inc;
                end
            end
            S_SEND: begin
                if (w_xfer_to) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_data_low_nxt = 1'b0;
                end else begin
                    w_xfer_cnt_nxt = w_xfer_inc;
                    if (w_fe) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state_nxt    = S_ACK;
                            w_data_low_nxt = 1'b0;
                        end else begin
                            w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
                            w_data_low_nxt = ~r_shift[0];
                            w_shift_nxt    = {1'b1, r_shift[8:1]};
                        end
                    end
                end
            end
            S_ACK: begin
                if (w_xfer_to || (w_fe && r_data_sync)) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_data_low_nxt = 1'b0;
                end else begin
                    w_xfer_cnt_nxt = w_xfer_inc;
                    if (w_fe) w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_xfer_to) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_data_low_nxt = 1'b0;
                end else begin
                    w_xfer_cnt_nxt = w_xfer_inc;
                    if (r_clk_sync && r_data_sync) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_data_low_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state            <= S_IDLE;
            r_clk_meta         <= 1'b1;
            r_clk_sync         <= 1'b1;
            r_clk_prev         <= 1'b1;
            r_data_meta        <= 1'b1;
            r_data_sync        <= 1'b1;
            r_inh_cnt          <= '0;
            r_start_cnt        <= '0;
            r_xfer_cnt         <= '0;
            r_bit_cnt          <= '0;
            r_shift            <= '0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            busy               <= 1'b0;
            tx_ready           <= 1'b1;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_clk_meta         <= ps2_clk_in;
            r_clk_sync         <= r_clk_meta;
            r_clk_prev         <= r_clk_sync;
            r_data_meta        <= ps2_data_in;
            r_data_sync        <= r_data_meta;
            r_inh_cnt          <= w_inh_cnt_nxt;
            r_start_cnt        <= w_start_cnt_nxt;
            r_xfer_cnt         <= w_xfer_cnt_nxt;
            r_bit_cnt          <= w_bit_cnt_nxt;
            r_shift            <= w_shift_nxt;
            ps2_clk_drive_low  <= w_clk_low_nxt;
            ps2_data_drive_low <= w_data_low_nxt;
            busy               <= (w_state_nxt != S_IDLE);
            tx_ready           <= (w_state_nxt == S_IDLE);
            done               <= w_done_nxt;
            err                <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks bits out of the host,
// samples them on rising edges and acks (or not); two instances cover both timeout settings.
module tb_ps2_host_tx;
    localparam int HALF = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tx_valid, sel, dev_clk, dev_data;
    logic [7:0] tx_data;
    logic       a_ready, a_clk_low, a_data_low, a_busy, a_done, a_err;
    logic       b_ready, b_clk_low, b_data_low, b_busy, b_done, b_err;
    logic       a_valid, b_valid, line_clk, line_data;
    logic       m_ready, m_clk_low, m_data_low, m_busy, m_done, m_err;

    // Wired-AND bus: device and both hosts can only pull low.
    assign line_clk  = dev_clk & ~a_clk_low & ~b_clk_low;
    assign line_data = dev_data & ~a_data_low & ~b_data_low;
    assign a_valid   = tx_valid & ~sel;
    assign b_valid   = tx_valid & sel;
    assign m_ready    = sel ? b_ready : a_ready;
    assign m_clk_low  = sel ? b_clk_low : a_clk_low;
    assign m_data_low = sel ? b_data_low : a_data_low;
    assign m_busy     = sel ? b_busy : a_busy;
    assign m_done     = sel ? b_done : a_done;
    assign m_err      = sel ? b_err : a_err;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .START_TIMEOUT(500), .XFER_TIMEOUT(1000)) u_dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .ps2_clk_in(line_clk), .ps2_data_in(line_data),
        .ps2_clk_drive_low(a_clk_low), .ps2_data_drive_low(a_data_low),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    ps2_host_tx #(.INHIBIT_CYCLES(20), .START_TIMEOUT(500), .XFER_TIMEOUT(300)) u_dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .ps2_clk_in(line_clk), .ps2_data_in(line_data),
        .ps2_clk_drive_low(b_clk_low), .ps2_data_drive_low(b_data_low),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_done | b_done) done_cnt <= done_cnt + 1;
        if (a_err | b_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {clk_low, data_low, busy, ready, done, err}
    function automatic logic [5:0] status();
        return {m_clk_low, m_data_low, m_busy, m_ready, m_done, m_err};
    endfunction

    // Requests a byte and measures the inhibit phase; returns at the clock-release sample.
    task automatic start_tx(input string tag, input logic [7:0] b, input bit inject);
        int n;
        logic first_d, last_d;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        first_d  = m_data_low;
        last_d   = 1'b0;
        n        = 0;
        while (m_clk_low === 1'b1 && n < 1000) begin
            n++;
            last_d = m_data_low;
            if (inject && n == 5) begin
                check({tag, " ready while busy"}, m_ready, 0);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check({tag, " inhibit length"}, n, 20);
        check({tag, " data released early inhibit"}, first_d, 0);
        check({tag, " start bit in last inhibit cycle"}, last_d, 1);
        check({tag, " data low at clock release"}, m_data_low, 1);
    endtask

    task automatic device_clock(input int n_fall, input bit ack_low, output logic [9:0] smp);
        smp = '0;
        repeat (30) @(negedge clk);
        for (int k = 1; k <= n_fall; k++) begin
            repeat (HALF / 2) @(negedge clk);
            if (k == 11 && ack_low) dev_data = 1'b0;
            repeat (HALF - HALF / 2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) smp[k-1] = line_data;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_pulse(input string tag, input bit want_err, input int bound, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < bound) begin
            @(negedge clk);
            if ((want_err ? m_err : m_done) === 1'b1) begin
                at = cyc;
                break;
            end
            n++;
        end
        check({tag, " pulse seen"}, (at >= 0), 1);
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    initial begin
        logic [9:0] smp;
        int d0, e0, t0, at;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sel      = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset idle status", status(), 6'b000100);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of the inhibit phase
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("inhibit active", {m_clk_low, m_busy, m_ready}, 3'b110);
        rst = 1'b0;
        @(negedge clk);
        check("reset releases lines", {m_clk_low, m_data_low}, 2'b00);
        repeat (2) @(negedge clk);
        check("reset mid-inhibit status", status(), 6'b000100);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("no pulse from reset", done_cnt + err_cnt - d0 - e0, 0);

        // 0xED with ack
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx("ed", 8'hED, 1'b0);
        device_clock(11, 1'b1, smp);
        check("ed sampled bits", smp, 10'b1_1_11101101);
        wait_pulse("ed done", 1'b0, 100, at);
        repeat (3) @(negedge clk);
        check("ed done count", done_cnt - d0, 1);
        check("ed err count", err_cnt - e0, 0);
        check("ed idle status", status(), 6'b000100);

        // 0xF4 with ack; 0x00 requested mid-inhibit must be ignored
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx("f4", 8'hF4, 1'b1);
        device_clock(11, 1'b1, smp);
        check("f4 sampled bits", smp, 10'b1_0_11110100);
        wait_pulse("f4 done", 1'b0, 100, at);
        repeat (3) @(negedge clk);
        check("f4 done count", done_cnt - d0, 1);
        check("f4 err count", err_cnt - e0, 0);

        // No device clock: start timeout
        d0 = done_cnt;
        start_tx("nodev", 8'hFF, 1'b0);
        t0 = cyc;
        wait_pulse("start timeout", 1'b1, 700, at);
        check("start timeout latency", (at - t0 >= 500) && (at - t0 <= 503), 1);
        check("lines released on err", {m_clk_low, m_data_low}, 2'b00);
        @(negedge clk);
        check("ready after start timeout", {m_ready, m_busy}, 2'b10);
        check("no done on start timeout", done_cnt - d0, 0);

        // Device leaves data high on the ack edge
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx("nack", 8'hF4, 1'b0);
        device_clock(11, 1'b0, smp);
        check("nack sampled bits", smp, 10'b1_0_11110100);
        repeat (10) @(negedge clk);
        check("nack err count", err_cnt - e0, 1);
        check("nack done count", done_cnt - d0, 0);
        check("nack idle status", status(), 6'b000100);

        // Device stalls after five edges on the short-timeout instance
        sel = 1'b1;
        d0  = done_cnt;
        start_tx("stall", 8'hED, 1'b0);
        t0 = cyc;
        device_clock(5, 1'b1, smp);
        wait_pulse("xfer timeout", 1'b1, 400, at);
        check("xfer timeout latency", (at - t0 >= 352) && (at - t0 <= 355), 1);
        repeat (2) @(negedge clk);
        check("stall idle status", status(), 6'b000100);
        check("no done on stall", done_cnt - d0, 0);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard.
- Complements the existing keyboard receive path by driving the same PS2_CLK/PS2_DATA lines in the opposite direction.
- Open-drain style: the block only requests "drive low". The top level ties each request to its inout as `line = drive_low ? 0 : 'z`.
- The receive decoder must ignore traffic while `busy` is high.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2_CLK is held low before the start bit (100 us at 100 MHz).
- START_TIMEOUT, 1500000, max cycles from clock release to the device's first falling edge (15 ms).
- XFER_TIMEOUT, 200000, max cycles from the first falling edge to ack complete (2 ms).

Ports:
- `clk`, input, 1, system clock.
- `rst`, input, 1, synchronous, active-low reset.
- `tx_data`, input, 8, command byte.
- `tx_valid`, input, 1, request to send `tx_data`.
- `tx_ready`, output, 1, high only in IDLE; a byte is accepted when `tx_valid && tx_ready`.
- `ps2_clk_in`, input, 1, PS2_CLK line level (asynchronous).
- `ps2_data_in`, input, 1, PS2_DATA line level (asynchronous).
- `ps2_clk_drive_low`, output, 1, 1 = pull PS2_CLK low.
- `ps2_data_drive_low`, output, 1, 1 = pull PS2_DATA low.
- `busy`, output, 1, high in every state except IDLE.
- `done`, output, 1, one-cycle pulse: device acknowledged the byte.
- `err`, output, 1, one-cycle pulse: timeout or missing ack.

Behaviour:
- Reset (`rst == 0` at a `clk` edge):
  - State goes to IDLE.
  - Both drive_low outputs = 0, `busy` = 0, `done` = 0, `err` = 0, `tx_ready` = 1.
  - Counters and the shift register are cleared.
  - Reset mid-transfer releases both lines on the same edge and sends no `done`/`err` pulse.
- Input conditioning:
  - `ps2_clk_in` and `ps2_data_in` each pass through a 2-flop synchronizer.
  - A falling edge (`fe`) is synced clk 1 followed by synced clk 0, giving 2–3 cycles of latency.
- All outputs are registered.
- Accept: in IDLE, `tx_valid` latches `tx_data` and computes `parity = ~^tx_data` (odd parity). `tx_valid` outside IDLE is ignored.
- IDLE: both lines released. On accept, go to INHIBIT.
- INHIBIT:
  - `ps2_clk_drive_low` = 1 for exactly INHIBIT_CYCLES cycles.
  - In the final cycle also assert `ps2_data_drive_low` = 1 (start bit), then go to REQ.
- REQ:
  - `ps2_clk_drive_low` = 0, `ps2_data_drive_low` stays 1.
  - Wait for `fe`. Timeout after START_TIMEOUT cycles -> ERR.
  - On `fe`: bit counter = 0, drive data bit0, go to SEND.
- SEND (counts falling edges k = 1..10; data is changed only on falling edges, and the device samples on rising edges):
  - After the fe numbered k = 1..8: drive data bit k-1, LSB first. Drive-low = ~bit.
  - After fe 9: drive the parity bit.
  - After fe 10: release data (stop bit = 1), go to ACK.
- ACK: on the next `fe` (the 11th), sample synced data.
  - 0 -> go to WAIT_IDLE.
  - 1 -> go to ERR.
- WAIT_IDLE: wait until synced clk = 1 and synced data = 1, then pulse `done` and go to IDLE.
- Transfer timer:
  - Starts at the first `fe` and covers SEND, ACK and WAIT_IDLE.
  - Exceeding XFER_TIMEOUT -> ERR.
- ERR: release both lines, pulse `err` for 1 cycle, go to IDLE. `done` and `err` never assert together.
- Simultaneous events: if a timeout and `fe` occur in the same cycle, the timeout wins.
- Bus arbitration: the host may inhibit at any time. A device transmission in progress when a request is accepted is aborted by the inhibit; there is no arbitration wait.
- Counter widths: each counter uses the minimum width that holds its parameter value. Counters saturate and do not wrap.

Test Plan:
- Reset: hold `rst` = 0 for 3 cycles mid-INHIBIT -> both drive_low = 0, `busy` = 0, `tx_ready` = 1, no `done`/`err`.
- Send 0xED, INHIBIT_CYCLES = 20, device model clocking at 20-cycle half-period and acking:
  - clk held low exactly 20 cycles, data low at clock release.
  - Data sampled on rising edges = 0, 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - `done` pulses once after lines return high.
- Send 0xF4 -> sampled data bits 0,0,1,0,1,1,1,1, parity 0, ack, `done`.
- No device clock, START_TIMEOUT = 500 -> `err` pulses 500 cycles after clock release (±3 sync cycles), lines released, `tx_ready` = 1.
- Device leaves data high on the ack edge -> `err` pulse, no `done`.
- Device stops clocking after 5 edges with XFER_TIMEOUT = 300 -> `err`.
- `tx_valid` pulsed with 0x00 while `busy` -> ignored; the in-flight byte is unchanged.
